// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall / bubble / flush control for the 5-stage MIPS pipeline.
// Resolves load-use hazards, taken branches and jumps, and multi-cycle data
// memory accesses; keeps saturating stall/flush statistics and a sticky
// memory-timeout error flag.
module hazard_stall_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IFID_UsesRt,
    input  logic [4:0]       IDEXRt,
    input  logic             IDEX_MemRead,
    input  logic             BranchTaken,
    input  logic             JumpID,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              freeze;
    logic              load_use;
    logic              wait_last;

    // Hazard detection from the current inputs and the registered state
    always_comb begin
        mem_stall = mem_req & ~mem_ready;
        freeze    = (state == MEM_WAIT) | mem_stall;
        load_use  = IDEX_MemRead & (IDEXRt != 5'd0) &
                    ((IDEXRt == IFIDRs) | (IFID_UsesRt & (IDEXRt == IFIDRt)));
        // This MEM_WAIT cycle is the TIMEOUT-th one
        wait_last = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    end

    // Pipeline controls by priority: reset, freeze, branch, load-use, jump
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        EXMEM_Hold  = 1'b0;
        if (reset) begin
            // Fill the front of the pipe with nops while reset is held
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (freeze) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            EXMEM_Hold = 1'b1;
        end else if (BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (load_use) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (JumpID) begin
            IFID_Flush = 1'b1;
        end
    end

    // Memory-wait FSM, wait counter, sticky error and saturating statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (!mem_req || wait_last) begin
                        // Request dropped mid-access or access too slow
                        mem_err <= 1'b1;
                        state   <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            if (!PCWrite && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (IFID_Flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (16-bit and 4-bit counters) share
// directed stimulus; a behavioural model is compared every cycle, and literal
// expectations pin the model at key points.
module tb_hazard_stall_unit;

    localparam int unsigned TO    = 4;
    localparam int unsigned W_A   = 16;
    localparam int unsigned W_B   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IFIDRs, IFIDRt, IDEXRt;
    logic       IFID_UsesRt, IDEX_MemRead, BranchTaken, JumpID, mem_req, mem_ready;

    logic           a_pc, a_ifw, a_fl, a_bub, a_hold, a_err;
    logic [W_A-1:0] a_stall, a_flush;
    logic           b_pc, b_ifw, b_fl, b_bub, b_hold, b_err;
    logic [W_B-1:0] b_stall, b_flush;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: waiting flag, MEM_WAIT cycles seen, sticky error, raw counts
    bit m_in_wait = 1'b0;
    int m_wait    = 0;
    bit m_err     = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.TIMEOUT(TO), .CNT_W(W_A)) u_a (
        .clk(clk), .reset(reset), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt),
        .IFID_UsesRt(IFID_UsesRt), .IDEXRt(IDEXRt), .IDEX_MemRead(IDEX_MemRead),
        .BranchTaken(BranchTaken), .JumpID(JumpID), .mem_req(mem_req),
        .mem_ready(mem_ready), .PCWrite(a_pc), .IFIDWrite(a_ifw),
        .IFID_Flush(a_fl), .IDEX_Bubble(a_bub), .EXMEM_Hold(a_hold),
        .mem_err(a_err), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    hazard_stall_unit #(.TIMEOUT(TO), .CNT_W(W_B)) u_b (
        .clk(clk), .reset(reset), .IFIDRs(IFIDRs), .IFIDRt(IFIDRt),
        .IFID_UsesRt(IFID_UsesRt), .IDEXRt(IDEXRt), .IDEX_MemRead(IDEX_MemRead),
        .BranchTaken(BranchTaken), .JumpID(JumpID), .mem_req(mem_req),
        .mem_ready(mem_ready), .PCWrite(b_pc), .IFIDWrite(b_ifw),
        .IFID_Flush(b_fl), .IDEX_Bubble(b_bub), .EXMEM_Hold(b_hold),
        .mem_err(b_err), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble, EXMEM_Hold}
    function automatic logic [4:0] model_ctl();
        bit frz, lu;
        if (reset) return 5'b00110;
        frz = m_in_wait || (mem_req && !mem_ready);
        lu  = IDEX_MemRead && (IDEXRt != 5'd0) &&
              ((IDEXRt == IFIDRs) || (IFID_UsesRt && (IDEXRt == IFIDRt)));
        if (frz)         return 5'b00001;
        if (BranchTaken) return 5'b11110;
        if (lu)          return 5'b00010;
        if (JumpID)      return 5'b11100;
        return 5'b11000;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model update on each rising edge
    always @(posedge clk) begin
        logic [4:0] c;
        if (reset) begin
            m_in_wait = 1'b0;
            m_wait    = 0;
            m_err     = 1'b0;
            m_stall   = 0;
            m_flush   = 0;
        end else begin
            c = model_ctl();
            if (!c[4]) m_stall++;
            if (c[2])  m_flush++;
            if (!m_in_wait) begin
                if (mem_req && !mem_ready) begin
                    m_in_wait = 1'b1;
                    m_wait    = 0;
                end
            end else begin
                m_wait++;
                if (mem_ready) begin
                    m_in_wait = 1'b0;
                end else if (!mem_req || m_wait >= int'(TO)) begin
                    m_err     = 1'b1;
                    m_in_wait = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_a", {26'd0, a_pc, a_ifw, a_fl, a_bub, a_hold, a_err, a_stall, a_flush},
                  {26'd0, model_ctl(), m_err, W_A'(sat(m_stall, W_A)), W_A'(sat(m_flush, W_A))});
            check("cycle_b", {50'd0, b_pc, b_ifw, b_fl, b_bub, b_hold, b_err, b_stall, b_flush},
                  {50'd0, model_ctl(), m_err, W_B'(sat(m_stall, W_B)), W_B'(sat(m_flush, W_B))});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IFIDRs = 5'd0; IFIDRt = 5'd0; IFID_UsesRt = 1'b0; IDEXRt = 5'd0;
        IDEX_MemRead = 1'b0; BranchTaken = 1'b0; JumpID = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        IDEX_MemRead = 1'b1; IDEXRt = rd; IFIDRs = rd;
    endtask

    function automatic logic [4:0] ctl_a();
        return {a_pc, a_ifw, a_fl, a_bub, a_hold};
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ctl", 64'(ctl_a()), 64'(5'b00110));
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ctl", 64'(ctl_a()), 64'(5'b11000));
        check("post_reset_stall", 64'(a_stall), 64'd0);

        // Load-use on rs: one stall, then the bubble clears the load
        step(); load_use(5'd8);
        @(negedge clk);
        check("lu_ctl", 64'(ctl_a()), 64'(5'b00010));
        step(); idle();
        @(negedge clk);
        check("lu_stall_cnt", 64'(a_stall), 64'd1);
        step(); load_use(5'd0);
        @(negedge clk);
        check("lu_r0_ctl", 64'(ctl_a()), 64'(5'b11000));

        // rt comparison gated by IFID_UsesRt
        step(); idle(); IDEX_MemRead = 1'b1; IDEXRt = 5'd9; IFIDRt = 5'd9; IFIDRs = 5'd3;
        @(negedge clk);
        check("rt_gated_ctl", 64'(ctl_a()), 64'(5'b11000));
        step(); IFID_UsesRt = 1'b1;
        @(negedge clk);
        check("rt_used_ctl", 64'(ctl_a()), 64'(5'b00010));
        step(); idle();
        @(negedge clk);
        check("rt_stall_cnt", 64'(a_stall), 64'd2);

        // Taken branch beats load-use
        step(); load_use(5'd8); BranchTaken = 1'b1;
        @(negedge clk);
        check("br_ctl", 64'(ctl_a()), 64'(5'b11110));
        step(); idle();
        @(negedge clk);
        check("br_flush_cnt", 64'(a_flush), 64'd1);
        check("br_stall_cnt", 64'(a_stall), 64'd2);

        // Jump alone flushes; jump with load-use gives load-use only
        step(); JumpID = 1'b1;
        @(negedge clk);
        check("jump_ctl", 64'(ctl_a()), 64'(5'b11100));
        step(); load_use(5'd5);
        @(negedge clk);
        check("jump_lu_ctl", 64'(ctl_a()), 64'(5'b00010));

        // Memory wait: ready after 3 waiting cycles, load-use pending throughout
        step(); idle(); load_use(5'd7); mem_req = 1'b1;
        @(negedge clk);
        check("mw_entry_ctl", 64'(ctl_a()), 64'(5'b00001));
        step(); step();
        @(negedge clk);
        check("mw_wait_ctl", 64'(ctl_a()), 64'(5'b00001));
        step(); mem_ready = 1'b1;
        @(negedge clk);
        check("mw_release_ctl", 64'(ctl_a()), 64'(5'b00001));
        step(); mem_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("mw_lu_after_ctl", 64'(ctl_a()), 64'(5'b00010));
        check("mw_stall_cnt", 64'(a_stall), 64'd7);
        check("mw_no_err", 64'(a_err), 64'd0);

        // Timeout: ready never comes
        step(); idle(); mem_req = 1'b1;
        step(); step(); step(); step();
        @(negedge clk);
        check("to_4th_wait_err", 64'(a_err), 64'd0);
        step(); mem_req = 1'b0;
        @(negedge clk);
        check("to_err_set", 64'(a_err), 64'd1);
        check("to_back_run_ctl", 64'(ctl_a()), 64'(5'b11000));
        check("to_stall_cnt", 64'(a_stall), 64'd13);
        step(); step(); step();
        @(negedge clk);
        check("to_err_sticky", 64'(a_err), 64'd1);

        // Reset while in MEM_WAIT abandons the access
        step(); mem_req = 1'b1;
        step(); reset = 1'b1;
        @(negedge clk);
        check("rst_wait_ctl", 64'(ctl_a()), 64'(5'b00110));
        step(); reset = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        check("rst_wait_run_ctl", 64'(ctl_a()), 64'(5'b11000));
        check("rst_wait_err", 64'(a_err), 64'd0);
        check("rst_wait_stall", 64'(a_stall), 64'd0);
        check("rst_wait_flush", 64'(a_flush), 64'd0);

        // 20 stall cycles: 4-bit counter saturates at 15
        step(); load_use(5'd12);
        for (int i = 0; i < 20; i++) step();
        idle();
        @(negedge clk);
        check("sat_a_stall", 64'(a_stall), 64'd20);
        check("sat_b_stall", 64'(b_stall), 64'd15);
        step(); step();
        @(negedge clk);
        check("sat_b_hold", 64'(b_stall), 64'd15);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
